ber_test_sequencer: RTL and testbench
=====================================

Name: ber_test_sequencer

Overview:
- Controller for the I and Q BER counter pair. It sequences each measurement: clear, then phase search, then a measurement window, then a result hold.
- Runs a lock timeout during phase search and latches coherent 64-bit error and bit snapshots.
- Serves the snapshots to the MicroBlaze over a 32-bit GPIO-style read port, one word per select code.
- Sits between the MicroBlaze GPIO block and both BER counters, and drives their shared reset and enable.

Parameters:
- NB_CNT, 64, width of the counter error and bit inputs.
- NB_BUS, 32, read-port width. NB_CNT must equal 2*NB_BUS.
- CLR_CYCLES, 4, number of cycles o_ber_reset is held high in CLEAR (must be ≥1).
- NB_TMO, 26, width of the timeout counter.
- TIMEOUT_CYCLES, 2**24, number of SEARCH cycles allowed before FAIL (must be ≤ 2**NB_TMO).

Ports:
- clock  in  1  system clock
- i_reset  in  1  reset, synchronous, active-high
- i_cmd_valid  in  1  one-cycle command strobe
- i_cmd  in  3  command code: 0 NOP, 1 START, 2 STOP, 3 CLEAR, 4 SNAPSHOT; codes 5-7 are ignored
- i_target  in  NB_BUS  bit-count target, zero-extended to NB_CNT; 0 means run until STOP
- i_fase_ok_i  in  1  I counter phase-lock flag
- i_fase_ok_q  in  1  Q counter phase-lock flag
- i_err_i  in  NB_CNT  live I error count
- i_bits_i  in  NB_CNT  live I bit count
- i_err_q  in  NB_CNT  live Q error count
- i_bits_q  in  NB_CNT  live Q bit count
- i_rd_sel  in  3  read select: 0/1 err_i lo/hi, 2/3 bits_i lo/hi, 4/5 err_q lo/hi, 6/7 bits_q lo/hi
- o_rd_data  out  NB_BUS  registered snapshot word
- o_ber_reset  out  1  reset to both BER counters
- o_ber_enable  out  1  enable to both BER counters
- o_state  out  3  current state encoding
- o_done  out  1  result valid (state HOLD)
- o_timeout  out  1  phase search timed out
- o_lost  out  1  lock was lost during MEASURE

Behaviour:
- States (Moore): IDLE=0, CLEAR=1, SEARCH=2, MEASURE=3, HOLD=4, FAIL=5. Outputs decode from the registered state.
- Reset values: state IDLE, o_ber_reset=1, o_ber_enable=0, o_done=0, o_timeout=0, o_lost=0, o_rd_data=0, all snapshots 0, timeout count 0, clear count 0.
- Output decode by state:
  - IDLE: o_ber_reset=1, o_ber_enable=0.
  - CLEAR: o_ber_reset=1, o_ber_enable=0.
  - SEARCH and MEASURE: o_ber_reset=0, o_ber_enable=1.
  - HOLD and FAIL: o_ber_reset=0, o_ber_enable=0.
- Command handling:
  - A command acts only in the cycle where i_cmd_valid=1. Commands that have no meaning in the current state are ignored.
  - CLEAR in any state: next state IDLE, all snapshots zeroed, o_timeout and o_lost cleared.
- IDLE:
  - START at cycle t: CLEAR during t+1..t+CLR_CYCLES, SEARCH at t+CLR_CYCLES+1.
- SEARCH:
  - The timeout counter is cleared on entry and increments each cycle.
  - i_fase_ok_i=1 and i_fase_ok_q=1 in the same cycle: next state MEASURE.
  - Count reaches TIMEOUT_CYCLES-1: next state FAIL, o_timeout=1.
  - Lock and timeout in the same cycle: lock wins.
  - STOP: next state IDLE.
- MEASURE:
  - Stop condition: i_target≠0 and both i_bits_i ≥ target and i_bits_q ≥ target (unsigned NB_CNT compare). Next state HOLD; all four counters are snapshotted in that same cycle.
  - STOP: next state HOLD with a snapshot.
  - Either fase_ok low: next state FAIL, o_lost=1, no snapshot.
  - SNAPSHOT: capture live counters, stay in MEASURE.
  - Priority when events coincide: CLEAR > STOP > loss of lock > target reached.
- HOLD:
  - o_done=1 and the snapshot is frozen.
  - START goes to CLEAR and clears o_done; the snapshot is retained until the next capture.
- FAIL:
  - Stays in FAIL until START (goes to CLEAR and clears o_timeout/o_lost) or CLEAR (goes to IDLE).
- Read port:
  - o_rd_data = selected snapshot half, registered, 1-cycle latency from i_rd_sel.
  - Reads never come from the live counters, so lo/hi word pairs are always coherent.
- Reset mid-operation: i_reset has priority over all commands and forces the reset values on the next edge.

Decomposition:
- Package ber_seq_pkg holds:
  - state encodings;
  - command codes CMD_NOP..CMD_SNAPSHOT;
  - read-select codes;
  - default constants for CLR_CYCLES and TIMEOUT_CYCLES.
- One sub-module, ber_snapshot_mux:
  - four NB_CNT snapshot registers with a capture input and a zero input;
  - registered 8:1 NB_BUS read mux.
- The FSM, clear counter and timeout counter stay in ber_test_sequencer.

Test Plan:
1. Reset, then START with CLR_CYCLES=4 and both fase_ok high → o_ber_reset high exactly 4 cycles, SEARCH for 1 cycle, then MEASURE with o_ber_enable=1.
2. TIMEOUT_CYCLES=16, fase_ok held low → FAIL after 16 SEARCH cycles, o_timeout=1, o_ber_enable=0; START then returns to CLEAR with o_timeout=0.
3. Target=1000; bits_i reaches 1000 while bits_q is at 999, then bits_q reaches 1000 → HOLD one cycle after bits_q=1000; rd_sel 2 → 1000 and rd_sel 6 → 1000, 1-cycle latency.
4. err_i=0x0000_0001_FFFF_FFFF at STOP, live counters keep changing afterwards → rd_sel 0 → 0xFFFF_FFFF and rd_sel 1 → 0x0000_0001, stable.
5. In MEASURE, drop i_fase_ok_q for 1 cycle → FAIL, o_lost=1, snapshots remain 0.
6. In MEASURE, STOP and CLEAR in the same cycle, and separately i_reset asserted → IDLE, snapshots 0, o_done=0, o_ber_reset=1.

Source files
------------

// File: rtl/ber_seq_pkg.sv
// Shared encodings for the BER test sequencer: FSM states, command codes,
// read-select codes and default timing constants.
package ber_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SEARCH  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_HOLD    = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_START    = 3'd1;
  localparam logic [2:0] CMD_STOP     = 3'd2;
  localparam logic [2:0] CMD_CLEAR    = 3'd3;
  localparam logic [2:0] CMD_SNAPSHOT = 3'd4;

  localparam logic [2:0] SEL_ERR_I_LO  = 3'd0;
  localparam logic [2:0] SEL_ERR_I_HI  = 3'd1;
  localparam logic [2:0] SEL_BITS_I_LO = 3'd2;
  localparam logic [2:0] SEL_BITS_I_HI = 3'd3;
  localparam logic [2:0] SEL_ERR_Q_LO  = 3'd4;
  localparam logic [2:0] SEL_ERR_Q_HI  = 3'd5;
  localparam logic [2:0] SEL_BITS_Q_LO = 3'd6;
  localparam logic [2:0] SEL_BITS_Q_HI = 3'd7;

  localparam int CLR_CYCLES_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 2**24;

endpackage

// File: rtl/ber_snapshot_mux.sv
// Four coherent counter snapshots plus a registered word-select read port.
// Reads only ever see the frozen copies, so lo/hi pairs always match.
module ber_snapshot_mux
  import ber_seq_pkg::*;
#(
  parameter int NB_CNT = 64,
  parameter int NB_BUS = 32
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_capture,
  input  logic              i_zero,
  input  logic [NB_CNT-1:0] i_err_i,
  input  logic [NB_CNT-1:0] i_bits_i,
  input  logic [NB_CNT-1:0] i_err_q,
  input  logic [NB_CNT-1:0] i_bits_q,
  input  logic [2:0]        i_rd_sel,
  output logic [NB_BUS-1:0] o_rd_data
);

  logic [NB_CNT-1:0] r_err_i;
  logic [NB_CNT-1:0] r_bits_i;
  logic [NB_CNT-1:0] r_err_q;
  logic [NB_CNT-1:0] r_bits_q;
  logic [NB_BUS-1:0] r_rd_data;
  logic [NB_BUS-1:0] w_word;

  // Zeroing wins over capture.
  always_ff @(posedge clock) begin
    if (i_reset || i_zero) begin
      r_err_i  <= '0;
      r_bits_i <= '0;
      r_err_q  <= '0;
      r_bits_q <= '0;
    end else if (i_capture) begin
      r_err_i  <= i_err_i;
      r_bits_i <= i_bits_i;
      r_err_q  <= i_err_q;
      r_bits_q <= i_bits_q;
    end
  end

  always_comb begin
    w_word = '0;
    case (i_rd_sel)
      SEL_ERR_I_LO:  w_word = r_err_i[NB_BUS-1:0];
      SEL_ERR_I_HI:  w_word = r_err_i[2*NB_BUS-1:NB_BUS];
      SEL_BITS_I_LO: w_word = r_bits_i[NB_BUS-1:0];
      SEL_BITS_I_HI: w_word = r_bits_i[2*NB_BUS-1:NB_BUS];
      SEL_ERR_Q_LO:  w_word = r_err_q[NB_BUS-1:0];
      SEL_ERR_Q_HI:  w_word = r_err_q[2*NB_BUS-1:NB_BUS];
      SEL_BITS_Q_LO: w_word = r_bits_q[NB_BUS-1:0];
      SEL_BITS_Q_HI: w_word = r_bits_q[2*NB_BUS-1:NB_BUS];
      default:       w_word = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) r_rd_data <= '0;
    else         r_rd_data <= w_word;
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ber_test_sequencer.sv
// Measurement sequencer for the I/Q BER counter pair: clear, phase search
// with timeout, measurement window, result hold; snapshots served to the CPU.
module ber_test_sequencer
  import ber_seq_pkg::*;
#(
  parameter int NB_CNT         = 64,
  parameter int NB_BUS         = 32,
  parameter int CLR_CYCLES     = CLR_CYCLES_DEF,
  parameter int NB_TMO         = 26,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [2:0]        i_cmd,
  input  logic [NB_BUS-1:0] i_target,
  input  logic              i_fase_ok_i,
  input  logic              i_fase_ok_q,
  input  logic [NB_CNT-1:0] i_err_i,
  input  logic [NB_CNT-1:0] i_bits_i,
  input  logic [NB_CNT-1:0] i_err_q,
  input  logic [NB_CNT-1:0] i_bits_q,
  input  logic [2:0]        i_rd_sel,
  output logic [NB_BUS-1:0] o_rd_data,
  output logic              o_ber_reset,
  output logic              o_ber_enable,
  output logic [2:0]        o_state,
  output logic              o_done,
  output logic              o_timeout,
  output logic              o_lost
);

  localparam int NB_CLR = $clog2(CLR_CYCLES + 1);

  state_t              r_state;
  state_t              w_next;
  logic [NB_CLR-1:0]   r_clr_cnt;
  logic [NB_TMO-1:0]   r_tmo_cnt;
  logic                r_timeout;
  logic                r_lost;
  logic                w_start, w_stop, w_clear, w_snap;
  logic                w_lock, w_target_hit, w_clr_last, w_tmo_last;
  logic                w_capture, w_zero, w_clr_flags, w_set_timeout, w_set_lost;
  logic [NB_CNT-1:0]   w_target_ext;

  // A command exists only in the cycle i_cmd_valid is high; there is no ready.
  always_comb begin
    w_start = 1'b0;
    w_stop  = 1'b0;
    w_clear = 1'b0;
    w_snap  = 1'b0;
    if (i_cmd_valid) begin
      case (i_cmd)
        CMD_NOP:      ;
        CMD_START:    w_start = 1'b1;
        CMD_STOP:     w_stop  = 1'b1;
        CMD_CLEAR:    w_clear = 1'b1;
        CMD_SNAPSHOT: w_snap  = 1'b1;
        default:      ;
      endcase
    end
  end

  assign w_target_ext = {{(NB_CNT-NB_BUS){1'b0}}, i_target};
  assign w_lock       = i_fase_ok_i && i_fase_ok_q;
  assign w_target_hit = (i_target != '0) && (i_bits_i >= w_target_ext) &&
                        (i_bits_q >= w_target_ext);
  assign w_clr_last   = (r_clr_cnt == NB_CLR'(CLR_CYCLES - 1));
  assign w_tmo_last   = (r_tmo_cnt == NB_TMO'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next        = r_state;
    w_capture     = 1'b0;
    w_zero        = 1'b0;
    w_clr_flags   = 1'b0;
    w_set_timeout = 1'b0;
    w_set_lost    = 1'b0;
    if (w_clear) begin
      w_next      = ST_IDLE;
      w_zero      = 1'b1;
      w_clr_flags = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_start) w_next = ST_CLEAR;
        ST_CLEAR:  if (w_clr_last) w_next = ST_SEARCH;
        ST_SEARCH: begin
          if (w_stop) w_next = ST_IDLE;
          else if (w_lock) w_next = ST_MEASURE;
          else if (w_tmo_last) begin
            w_next        = ST_FAIL;
            w_set_timeout = 1'b1;
          end
        end
        ST_MEASURE: begin
          if (w_stop) begin
            w_next    = ST_HOLD;
            w_capture = 1'b1;
          end else if (!w_lock) begin
            w_next     = ST_FAIL;
            w_set_lost = 1'b1;
          end else if (w_target_hit) begin
            w_next    = ST_HOLD;
            w_capture = 1'b1;
          end else if (w_snap) begin
            w_capture = 1'b1;
          end
        end
        ST_HOLD, ST_FAIL: begin
          if (w_start) begin
            w_next      = ST_CLEAR;
            w_clr_flags = 1'b1;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Both counters restart from zero every time their state is entered.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
      r_lost    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_clr_cnt <= (r_state == ST_CLEAR)  ? r_clr_cnt + NB_CLR'(1) : '0;
      r_tmo_cnt <= (r_state == ST_SEARCH) ? r_tmo_cnt + NB_TMO'(1) : '0;
      if (w_clr_flags) begin
        r_timeout <= 1'b0;
        r_lost    <= 1'b0;
      end else begin
        if (w_set_timeout) r_timeout <= 1'b1;
        if (w_set_lost)    r_lost    <= 1'b1;
      end
    end
  end

  assign o_state      = r_state;
  assign o_ber_reset  = (r_state == ST_IDLE) || (r_state == ST_CLEAR);
  assign o_ber_enable = (r_state == ST_SEARCH) || (r_state == ST_MEASURE);
  assign o_done       = (r_state == ST_HOLD);
  assign o_timeout    = r_timeout;
  assign o_lost       = r_lost;

  ber_snapshot_mux #(
    .NB_CNT (NB_CNT),
    .NB_BUS (NB_BUS)
  ) u_snap (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_capture (w_capture),
    .i_zero    (w_zero),
    .i_err_i   (i_err_i),
    .i_bits_i  (i_bits_i),
    .i_err_q   (i_err_q),
    .i_bits_q  (i_bits_q),
    .i_rd_sel  (i_rd_sel),
    .o_rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_ber_test_sequencer.sv
// Directed-plus-random bench for ber_test_sequencer with a snapshot model
// (four 64-bit values) and an expected-word queue for the read port.
module tb_ber_test_sequencer;
  import ber_seq_pkg::*;

  localparam int NB_CNT = 64;
  localparam int NB_BUS = 32;
  localparam int CLR    = 4;
  localparam int TMO    = 16;

  logic              clock = 1'b0;
  logic              i_reset;
  logic              i_cmd_valid;
  logic [2:0]        i_cmd;
  logic [NB_BUS-1:0] i_target;
  logic              i_fase_ok_i, i_fase_ok_q;
  logic [NB_CNT-1:0] i_err_i, i_bits_i, i_err_q, i_bits_q;
  logic [2:0]        i_rd_sel;
  logic [NB_BUS-1:0] o_rd_data;
  logic              o_ber_reset, o_ber_enable, o_done, o_timeout, o_lost;
  logic [2:0]        o_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [NB_CNT-1:0] exp_snap [4];
  logic [NB_BUS-1:0] exp_q [$];

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  ber_test_sequencer #(
    .NB_CNT         (NB_CNT),
    .NB_BUS         (NB_BUS),
    .CLR_CYCLES     (CLR),
    .NB_TMO         (26),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_cmd_valid  (i_cmd_valid),
    .i_cmd        (i_cmd),
    .i_target     (i_target),
    .i_fase_ok_i  (i_fase_ok_i),
    .i_fase_ok_q  (i_fase_ok_q),
    .i_err_i      (i_err_i),
    .i_bits_i     (i_bits_i),
    .i_err_q      (i_err_q),
    .i_bits_q     (i_bits_q),
    .i_rd_sel     (i_rd_sel),
    .o_rd_data    (o_rd_data),
    .o_ber_reset  (o_ber_reset),
    .o_ber_enable (o_ber_enable),
    .o_state      (o_state),
    .o_done       (o_done),
    .o_timeout    (o_timeout),
    .o_lost       (o_lost)
  );

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd       = CMD_NOP;
  endtask

  task automatic set_live_random();
    i_err_i  = {$urandom, $urandom};
    i_bits_i = {$urandom, $urandom};
    i_err_q  = {$urandom, $urandom};
    i_bits_q = {$urandom, $urandom};
  endtask

  task automatic model_capture();
    exp_snap[0] = i_err_i;
    exp_snap[1] = i_bits_i;
    exp_snap[2] = i_err_q;
    exp_snap[3] = i_bits_q;
  endtask

  task automatic model_zero();
    for (int k = 0; k < 4; k++) exp_snap[k] = '0;
  endtask

  function automatic logic [NB_BUS-1:0] exp_word(input int s);
    logic [NB_CNT-1:0] v;
    v = exp_snap[s / 2];
    return (s % 2 == 1) ? v[63:32] : v[31:0];
  endfunction

  task automatic read_all(input string tag);
    logic [NB_BUS-1:0] w;
    for (int s = 0; s < 8; s++) exp_q.push_back(exp_word(s));
    for (int s = 0; s < 8; s++) begin
      i_rd_sel = s[2:0];
      tick();
      w = exp_q.pop_front();
      chk($sformatf("%s_sel%0d", tag, s), 64'(o_rd_data), 64'(w));
    end
  endtask

  task automatic wait_state(input string tag, input state_t st);
    int n = 0;
    while (o_state !== 3'(st) && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 64'(o_state), 64'(st));
  endtask

  task automatic go_measure(input string tag);
    do_cmd(CMD_START);
    wait_state(tag, ST_MEASURE);
  endtask

  initial begin
    int n;
    i_reset     = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd       = CMD_NOP;
    i_target    = '0;
    i_fase_ok_i = 1'b1;
    i_fase_ok_q = 1'b1;
    i_rd_sel    = 3'd0;
    set_live_random();
    model_zero();
    tick();
    tick();
    chk("rst_state", 64'(o_state), 64'(ST_IDLE));
    chk("rst_ber_reset", 64'(o_ber_reset), 64'd1);
    chk("rst_enable", 64'(o_ber_enable), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_flags", 64'({o_timeout, o_lost}), 64'd0);
    chk("rst_rd_data", 64'(o_rd_data), 64'd0);
    i_reset = 1'b0;
    tick();
    chk("idle_hold", 64'(o_state), 64'(ST_IDLE));

    // START: reset held for exactly CLR cycles, one SEARCH cycle, then MEASURE
    do_cmd(CMD_START);
    chk("start_clear", 64'(o_state), 64'(ST_CLEAR));
    n = 0;
    while (o_ber_reset === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("clr_len", 64'(n), 64'(CLR));
    chk("search_state", 64'(o_state), 64'(ST_SEARCH));
    chk("search_enable", 64'(o_ber_enable), 64'd1);
    tick();
    chk("measure_state", 64'(o_state), 64'(ST_MEASURE));
    chk("measure_enable", 64'({o_ber_enable, o_ber_reset}), 64'b10);

    // random SNAPSHOTs with target 0 (runs until STOP)
    for (int r = 0; r < 3; r++) begin
      set_live_random();
      model_capture();
      do_cmd(CMD_SNAPSHOT);
      chk("snap_stays", 64'(o_state), 64'(ST_MEASURE));
      set_live_random();
      read_all($sformatf("snap%0d", r));
    end
    for (int c = 5; c < 8; c++) begin
      do_cmd(c[2:0]);
      chk($sformatf("ignored_cmd%0d", c), 64'(o_state), 64'(ST_MEASURE));
    end
    do_cmd(CMD_START);
    chk("ignored_start", 64'(o_state), 64'(ST_MEASURE));

    // STOP snapshot stays coherent while live counters move
    set_live_random();
    i_err_i = 64'h0000_0001_FFFF_FFFF;
    model_capture();
    do_cmd(CMD_STOP);
    chk("stop_hold", 64'(o_state), 64'(ST_HOLD));
    chk("stop_done", 64'(o_done), 64'd1);
    chk("hold_outs", 64'({o_ber_enable, o_ber_reset}), 64'b00);
    for (int r = 0; r < 3; r++) begin
      set_live_random();
      i_rd_sel = 3'd0;
      tick();
      chk("stop_err_i_lo", 64'(o_rd_data), 64'hFFFF_FFFF);
      i_rd_sel = 3'd1;
      tick();
      chk("stop_err_i_hi", 64'(o_rd_data), 64'h0000_0001);
    end
    read_all("stop");

    // target reached only once both bit counts reach it
    i_bits_i = '0;
    i_bits_q = '0;
    i_target = 32'd1000;
    do_cmd(CMD_START);
    chk("hold_start_done", 64'(o_done), 64'd0);
    wait_state("tgt_measure", ST_MEASURE);
    for (int r = 0; r < 4; r++) begin
      i_bits_i = 64'($urandom_range(0, 999));
      i_bits_q = 64'($urandom_range(0, 1100));
      if (r == 3) i_bits_q = 64'd1000;
      tick();
      chk("tgt_below", 64'(o_state), 64'(ST_MEASURE));
    end
    i_bits_i = 64'd1000;
    i_bits_q = 64'd999;
    tick();
    chk("tgt_q_999", 64'(o_state), 64'(ST_MEASURE));
    i_bits_q = 64'd1000;
    model_capture();
    tick();
    chk("tgt_hold", 64'(o_state), 64'(ST_HOLD));
    set_live_random();
    i_rd_sel = 3'd0;
    tick();
    chk("tgt_rd0", 64'(o_rd_data), 64'(exp_word(0)));
    i_rd_sel = 3'd2;
    #1;
    chk("tgt_latency", 64'(o_rd_data), 64'(exp_word(0)));
    tick();
    chk("tgt_bits_i", 64'(o_rd_data), 64'd1000);
    i_rd_sel = 3'd6;
    tick();
    chk("tgt_bits_q", 64'(o_rd_data), 64'd1000);

    // phase-search timeout after TMO cycles
    i_target    = '0;
    i_fase_ok_i = 1'b0;
    i_fase_ok_q = 1'b0;
    do_cmd(CMD_START);
    wait_state("tmo_search", ST_SEARCH);
    n = 0;
    while (o_state === 3'(ST_SEARCH) && n < 100) begin
      n++;
      tick();
    end
    chk("tmo_len", 64'(n), 64'(TMO));
    chk("tmo_fail", 64'(o_state), 64'(ST_FAIL));
    chk("tmo_flag", 64'(o_timeout), 64'd1);
    chk("tmo_outs", 64'({o_ber_enable, o_ber_reset}), 64'b00);
    tick();
    chk("fail_sticky", 64'(o_state), 64'(ST_FAIL));
    do_cmd(CMD_START);
    chk("fail_start", 64'(o_state), 64'(ST_CLEAR));
    chk("fail_start_tmo", 64'(o_timeout), 64'd0);

    // lock arriving in the last allowed SEARCH cycle wins over timeout
    wait_state("lock_search", ST_SEARCH);
    repeat (TMO - 1) tick();
    chk("lock_last_cycle", 64'(o_state), 64'(ST_SEARCH));
    i_fase_ok_i = 1'b1;
    i_fase_ok_q = 1'b1;
    tick();
    chk("lock_wins", 64'(o_state), 64'(ST_MEASURE));
    chk("lock_wins_tmo", 64'(o_timeout), 64'd0);

    do_cmd(CMD_CLEAR);
    model_zero();
    chk("clear_idle", 64'(o_state), 64'(ST_IDLE));
    read_all("clear");

    // loss of lock in MEASURE
    go_measure("lost_measure");
    i_fase_ok_q = 1'b0;
    tick();
    i_fase_ok_q = 1'b1;
    chk("lost_fail", 64'(o_state), 64'(ST_FAIL));
    chk("lost_flag", 64'(o_lost), 64'd1);
    chk("lost_enable", 64'(o_ber_enable), 64'd0);
    read_all("lost");
    do_cmd(CMD_START);
    chk("lost_restart", 64'(o_state), 64'(ST_CLEAR));
    chk("lost_cleared", 64'(o_lost), 64'd0);

    // CLEAR during MEASURE
    wait_state("clr_measure", ST_MEASURE);
    set_live_random();
    model_capture();
    do_cmd(CMD_SNAPSHOT);
    do_cmd(CMD_CLEAR);
    model_zero();
    chk("mclr_state", 64'(o_state), 64'(ST_IDLE));
    chk("mclr_outs", 64'({o_done, o_ber_reset}), 64'b01);
    read_all("mclr");

    // reset beats a simultaneous command
    go_measure("rst_measure");
    set_live_random();
    model_capture();
    do_cmd(CMD_STOP);
    chk("rst_pre_hold", 64'(o_state), 64'(ST_HOLD));
    i_reset     = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd       = CMD_START;
    tick();
    i_reset     = 1'b0;
    i_cmd_valid = 1'b0;
    model_zero();
    chk("mrst_state", 64'(o_state), 64'(ST_IDLE));
    chk("mrst_outs", 64'({o_done, o_ber_reset, o_ber_enable}), 64'b010);
    chk("mrst_rd", 64'(o_rd_data), 64'd0);
    read_all("mrst");
    go_measure("rst2_measure");
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("mrst2_state", 64'(o_state), 64'(ST_IDLE));
    chk("mrst2_enable", 64'(o_ber_enable), 64'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
